// File: rtl/m_stage_dm.sv
// Memory-stage data memory: byte-lane stores into a word array and
// extended loads returned to the M/W register.
module m_stage_dm #(
    parameter int DEPTH = 3072,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] M_pc,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_wdata,
    input  logic [1:0]  M_store_op,
    input  logic [2:0]  M_load_op,
    output logic [3:0]  M_byteen,
    output logic [31:0] M_Rdata
);

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;
    localparam logic [1:0] ST_SW = 2'b11;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      raw;
    logic [31:0]      wlanes;
    logic [31:0]      merged;
    logic             we;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;

    assign idx      = M_addr[IDX_W+1:2];
    assign in_range = {1'b0, idx} < (IDX_W+1)'(DEPTH);
    assign raw      = in_range ? mem[idx] : 32'h0;
    assign we       = (M_byteen != 4'b0000) && in_range;

    always_comb begin
        M_byteen = 4'b0000;
        wlanes   = M_wdata;
        unique case (M_store_op)
            ST_SB: begin
                M_byteen = 4'b0001 << M_addr[1:0];
                wlanes   = {4{M_wdata[7:0]}};
            end
            ST_SH: begin
                M_byteen = M_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{M_wdata[15:0]}};
            end
            ST_SW: M_byteen = 4'b1111;
            default: M_byteen = 4'b0000;
        endcase
    end

    // Untouched lanes keep the stored bytes.
    always_comb begin
        merged = raw;
        for (int b = 0; b < 4; b++) begin
            if (M_byteen[b]) merged[8*b +: 8] = wlanes[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (we) begin
            mem[idx] <= merged;
            $display("%d@%h: *%h <= %h", $time, M_pc,
                     {M_addr[31:2], 2'b00}, merged);
        end
    end

    always_comb begin
        sel_byte = raw[7:0];
        unique case (M_addr[1:0])
            2'd0: sel_byte = raw[7:0];
            2'd1: sel_byte = raw[15:8];
            2'd2: sel_byte = raw[23:16];
            2'd3: sel_byte = raw[31:24];
            default: sel_byte = raw[7:0];
        endcase
    end

    assign sel_half = M_addr[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        M_Rdata = raw;
        unique case (M_load_op)
            LD_LB:   M_Rdata = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU:  M_Rdata = {24'h0, sel_byte};
            LD_LH:   M_Rdata = {{16{sel_half[15]}}, sel_half};
            LD_LHU:  M_Rdata = {16'h0, sel_half};
            default: M_Rdata = raw;
        endcase
    end

endmodule

// File: tb/tb_m_stage_dm.sv
// Scoreboard bench for m_stage_dm: expected load data and lane enables
// are queued as stimulus is driven and compared when sampled.
module tb_m_stage_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] M_pc;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic [1:0]  M_store_op;
    logic [2:0]  M_load_op;
    logic [3:0]  M_byteen;
    logic [31:0] M_Rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd_q [$];
    logic [3:0]  be_q [$];
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;

    m_stage_dm dut (
        .clk        (clk),
        .rst        (rst),
        .M_pc       (M_pc),
        .M_addr     (M_addr),
        .M_wdata    (M_wdata),
        .M_store_op (M_store_op),
        .M_load_op  (M_load_op),
        .M_byteen   (M_byteen),
        .M_Rdata    (M_Rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic [1:0] st, input logic [2:0] ld,
                         input logic [31:0] a, input logic [31:0] wd);
        M_store_op = st;
        M_load_op  = ld;
        M_addr     = a;
        M_wdata    = wd;
        M_pc       = M_pc + 32'd4;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(2'b00, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0);
        rd_q.push_back(32'h0);
        be_q.push_back(4'b0000);
        #1;
        exp_rd = rd_q.pop_front();
        exp_be = be_q.pop_front();
        n_assert += 2;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want %h", M_Rdata, exp_rd);
        end
        if (M_byteen !== exp_be) begin
            n_fail++;
            $display("FAIL reset_byteen got %b want %b", M_byteen, exp_be);
        end
        @(negedge clk);
        drive(2'b11, 3'b000, 32'h0, 32'h12345678);
        @(negedge clk);
        drive(2'b00, 3'b000, 32'h0, 32'h0);
        rd_q.push_back(32'h12345678);
        #1;
        exp_rd = rd_q.pop_front();
        n_assert++;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL pre_reset_word got %h want %h", M_Rdata, exp_rd);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 3'b000, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0);
        rd_q.push_back(32'h0);
        #1;
        exp_rd = rd_q.pop_front();
        n_assert++;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_clears got %h want %h", M_Rdata, exp_rd);
        end
    endtask

    task automatic test_word;
        @(negedge clk);
        drive(2'b11, 3'b000, 32'h10, 32'hDEADBEEF);
        be_q.push_back(4'b1111);
        #1;
        exp_be = be_q.pop_front();
        n_assert++;
        if (M_byteen !== exp_be) begin
            n_fail++;
            $display("FAIL sw_byteen got %b want %b", M_byteen, exp_be);
        end
        @(negedge clk);
        drive(2'b00, 3'b000, 32'h10, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        #1;
        exp_rd = rd_q.pop_front();
        n_assert++;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL lw_word got %h want %h", M_Rdata, exp_rd);
        end
    endtask

    task automatic test_byte_merge;
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b010, 3'b001};
        logic [31:0] adr [4] = '{32'h10, 32'h13, 32'h13, 32'h10};
        logic [31:0] exv [4] = '{32'hDE11BEEF, 32'hFFFFFFDE,
                                 32'h000000DE, 32'hFFFFFFEF};
        @(negedge clk);
        drive(2'b01, 3'b000, 32'h12, 32'h00000011);
        be_q.push_back(4'b0100);
        #1;
        exp_be = be_q.pop_front();
        n_assert++;
        if (M_byteen !== exp_be) begin
            n_fail++;
            $display("FAIL sb_byteen got %b want %b", M_byteen, exp_be);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, ops[i], adr[i], 32'h0);
            rd_q.push_back(exv[i]);
            #1;
            exp_rd = rd_q.pop_front();
            n_assert++;
            if (M_Rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL byte_load_%0d got %h want %h",
                         i, M_Rdata, exp_rd);
            end
        end
    endtask

    task automatic test_half;
        logic [2:0]  ops [4] = '{3'b000, 3'b011, 3'b100, 3'b011};
        logic [31:0] adr [4] = '{32'h20, 32'h22, 32'h22, 32'h20};
        logic [31:0] exv [4] = '{32'hABCD0000, 32'hFFFFABCD,
                                 32'h0000ABCD, 32'h00000000};
        @(negedge clk);
        drive(2'b10, 3'b000, 32'h22, 32'h0000ABCD);
        be_q.push_back(4'b1100);
        #1;
        exp_be = be_q.pop_front();
        n_assert++;
        if (M_byteen !== exp_be) begin
            n_fail++;
            $display("FAIL sh_byteen got %b want %b", M_byteen, exp_be);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, ops[i], adr[i], 32'h0);
            rd_q.push_back(exv[i]);
            #1;
            exp_rd = rd_q.pop_front();
            n_assert++;
            if (M_Rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL half_load_%0d got %h want %h",
                         i, M_Rdata, exp_rd);
            end
        end
    endtask

    task automatic test_boundary;
        logic [31:0] sadr [3] = '{32'h2FFC, 32'h3000, 32'h7};
        logic [31:0] sdat [3] = '{32'h55AA55AA, 32'h12345678, 32'h1};
        logic [31:0] ladr [3] = '{32'h2FFC, 32'h3000, 32'h4};
        logic [31:0] exv  [3] = '{32'h55AA55AA, 32'h0, 32'h1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b11, 3'b000, sadr[i], sdat[i]);
            @(negedge clk);
            drive(2'b00, 3'b000, ladr[i], 32'h0);
            rd_q.push_back(exv[i]);
            #1;
            exp_rd = rd_q.pop_front();
            n_assert++;
            if (M_Rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL boundary_%0d got %h want %h",
                         i, M_Rdata, exp_rd);
            end
        end
        drive(2'b00, 3'b010, 32'h3001, 32'h0);
        rd_q.push_back(32'h0);
        #1;
        exp_rd = rd_q.pop_front();
        n_assert++;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL oor_lbu got %h want %h", M_Rdata, exp_rd);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(2'b11, 3'b000, 32'h40, 32'(i));
        end
        @(negedge clk);
        drive(2'b00, 3'b000, 32'h40, 32'h0);
        rd_q.push_back(32'h3);
        #1;
        exp_rd = rd_q.pop_front();
        n_assert++;
        if (M_Rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL back_to_back got %h want %h", M_Rdata, exp_rd);
        end
    endtask

    initial begin
        rst        = 1'b1;
        M_pc       = 32'h00003000;
        M_addr     = 32'h0;
        M_wdata    = 32'h0;
        M_store_op = 2'b00;
        M_load_op  = 3'b000;
        test_reset();
        test_word();
        test_byte_merge();
        test_half();
        test_boundary();
        test_back_to_back();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
